// File: rtl/filter_weight_loader_pkg.sv
// Shared constants, types and index decode for the filter weight loader.
package filter_weight_loader_pkg;

    localparam int WIDTH  = 17;
    localparam int N_FILT = 4;
    localparam int N_CH   = 3;
    localparam int K      = 3;
    localparam int TOTAL  = N_FILT * N_CH * K * K;

    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int F_W    = $clog2(N_FILT);
    localparam int C_W    = $clog2(N_CH);
    localparam int K_W    = $clog2(K);

    typedef logic signed [WIDTH-1:0] weight_t;

    // Same [filter][channel][column][row] layout the conv datapath reads from the ROM
    typedef weight_t filt_bank_t [N_FILT][N_CH][K][K];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef struct packed {
        logic [F_W-1:0] f;
        logic [C_W-1:0] c;
        logic [K_W-1:0] col;
        logic [K_W-1:0] row;
    } bank_addr_t;

    // Stream order is row fastest, then column, then channel, then filter
    function automatic bank_addr_t decode_idx(input logic [CNT_W-1:0] idx);
        bank_addr_t  a;
        int unsigned rem;
        rem   = 32'(idx);
        a.row = K_W'(rem % K);
        rem   = rem / K;
        a.col = K_W'(rem % K);
        rem   = rem / K;
        a.c   = C_W'(rem % N_CH);
        a.f   = F_W'(rem / N_CH);
        return a;
    endfunction

endpackage

// File: rtl/filter_weight_loader_bank_regs.sv
// Shadow bank (written beat by beat) and active bank (updated only on swap).
module filter_weight_loader_bank_regs
    import filter_weight_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       swap_en,
    input  bank_addr_t wr_addr,
    input  weight_t    wr_data,
    output filt_bank_t active
);

    filt_bank_t shadow;

    // Shadow write port: one weight per accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '{default: '0};
        end else if (wr_en) begin
            shadow[wr_addr.f][wr_addr.c][wr_addr.col][wr_addr.row] <= wr_data;
        end
    end

    // Swap copies the shadow and folds in the final beat, which is not in the shadow yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '{default: '0};
        end else if (swap_en) begin
            active <= shadow;
            active[wr_addr.f][wr_addr.c][wr_addr.col][wr_addr.row] <= wr_data;
        end
    end

endmodule

// File: rtl/filter_weight_loader.sv
// Run-time reloadable conv-filter weights: streams into a shadow bank and
// swaps it into the active bank only after a correctly framed load.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no load since reset; stream not accepted
//   LOAD  | accepting beats into the shadow bank
//   DONE  | last load framed correctly and swapped into active bank
//   ERR   | last load mis-framed; active bank left untouched
module filter_weight_loader
    import filter_weight_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  weight_t          s_data,
    input  logic             s_last,
    output logic             busy,
    output logic             load_err,
    output logic             weights_valid,
    output logic [CNT_W-1:0] load_count,
    output filt_bank_t       filt_out
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr_en;
    logic             at_end;
    logic             swap_en;

    // start wins over a beat arriving in the same cycle, so that beat is dropped
    assign wr_en      = s_valid & s_ready & ~start;
    assign at_end     = (cnt == CNT_W'(TOTAL - 1));
    assign swap_en    = wr_en & s_last & at_end;
    assign load_count = cnt;

    filter_weight_loader_bank_regs u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .swap_en (swap_en),
        .wr_addr (decode_idx(cnt)),
        .wr_data (s_data),
        .active  (filt_out)
    );

    // Load sequencing, beat counting and framing checks, all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
            load_err      <= 1'b0;
            weights_valid <= 1'b0;
        end else if (start) begin
            state    <= LOAD;
            cnt      <= '0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            load_err <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_en) begin
                        cnt <= cnt + 1'b1;
                        if (at_end || s_last) begin
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            if (at_end && s_last) begin
                                state         <= DONE;
                                weights_valid <= 1'b1;
                            end else begin
                                state    <= ERR;
                                load_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/filter_weight_loader.md
Name: filter_weight_loader

Overview:
- Writer-side counterpart of the fixed stage-2 filter ROM.
- Accepts conv-filter weights over a valid/ready stream and stores them in a shadow bank.
- On a correctly framed load, swaps the shadow bank into the active bank. The active bank drives the same [filter][channel][column][row] array layout that the conv datapath reads from the ROM.
- Allows weights to be reprogrammed at run time without stalling consumers of the active bank.

Parameters:
- WIDTH, 17, bits per signed weight (Q-format, sign bit + fraction; no conversion done here).
- N_FILT, 4, number of filters.
- N_CH, 3, input channels per filter.
- K, 3, kernel size (K x K).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new load
- s_valid  in  1  weight beat valid
- s_ready  out  1  loader accepts a beat
- s_data  in  WIDTH  signed weight
- s_last  in  1  marks the final beat of a load
- busy  out  1  load in progress
- load_err  out  1  sticky; last load was mis-framed
- weights_valid  out  1  active bank holds a successfully loaded set
- load_count  out  $clog2(N_FILT*N_CH*K*K+1)  beats accepted in the current or last load
- filt_out  out  signed WIDTH, unpacked [N_FILT][N_CH][K][K]  active bank, index order [filter][channel][column][row]

Behaviour:
- TOTAL = N_FILT*N_CH*K*K; 108 at defaults.
- Reset values: every output is 0, FSM is IDLE, both banks are all-zero.
- FSM states:
  - IDLE: s_ready=0, busy=0.
  - LOAD: s_ready=1, busy=1.
  - DONE: s_ready=0, busy=0.
  - ERR: s_ready=0, busy=0, load_err=1.
- Transitions:
  - IDLE/DONE/ERR + start -> LOAD. Index counter clears to 0, load_count clears to 0, load_err clears. weights_valid is not changed.
  - LOAD, beat accepted (s_valid & s_ready): write s_data to shadow[idx], then idx++ and load_count++.
  - Stream order is row fastest, then column, then channel, then filter: idx = ((f*N_CH + c)*K + col)*K + row.
  - Accepted beat with idx==TOTAL-1 and s_last=1 -> DONE. On the same edge the active bank takes the shadow contents, including this final beat, and weights_valid is set to 1. filt_out changes on the cycle after that final acceptance, so latency is 1.
  - Accepted beat with s_last=1 and idx<TOTAL-1 (early last) -> ERR.
  - Accepted beat with idx==TOTAL-1 and s_last=0 (missing last) -> ERR.
  - In ERR, the active bank and weights_valid are unchanged. The shadow holds partial data, which is don't-care.
- start while in LOAD aborts the current load and restarts it from idx 0. A beat accepted in the same cycle is discarded; start has priority.
- s_valid while not in LOAD is ignored; no handshake occurs.
- The active bank never changes except by a full, correctly framed swap or by reset. filt_out is glitch-free and fully registered.
- s_data is stored bit-exact; there is no saturation or sign extension.
- Reset mid-load: all state returns to reset values immediately (asynchronous), including the active bank.
- Back-to-back beats are sustained at 1 per cycle, so a full load takes TOTAL cycles plus 1 for the swap.

Decomposition:
- Shared package (e.g. cnn_pkg) holds:
  - WIDTH, N_FILT, N_CH, K and TOTAL constants.
  - A weight_t signed typedef.
  - A filt_bank_t typedef for the [N_FILT][N_CH][K][K] array.
  - The FSM state enum.
  - An index-to-(f,c,col,row) decode function.
- One natural sub-module: weight_bank_regs. It holds the shadow write port, the active bank and the swap-enable. The loader top keeps the FSM, counter and framing checks.

Test Plan:
- Reset, then full load of 108 beats with s_data = idx and s_last on beat 107 -> weights_valid=1 one cycle later; filt_out[1][2][0][1] = 46; load_err=0; load_count=108.
- Load with s_valid toggling every other cycle -> the same final bank as the back-to-back case; s_ready stays high throughout LOAD; busy drops in the cycle after the swap.
- After a good load of idx values, start a second load asserting s_last at beat 50 -> state ERR, load_err=1, filt_out still equal to the first load, weights_valid=1, load_count=51.
- Load 108 beats with s_last never asserted -> ERR after beat 107, active bank unchanged. A following start clears load_err, and a clean load of 0x1FFFF everywhere makes every filt_out element equal -1.
- start pulsed at beat 30 of a load, then a clean 108-beat load -> the bank reflects only the second load; no beat from the aborted load is visible.
- rst asserted asynchronously mid-load, between clock edges -> all outputs 0 immediately, including filt_out and weights_valid; s_ready=0 until the next start.
